// File: rtl/magnitude_pkg.sv
// Shared types and constants for the magnitude arbiter and its tag FIFO.
package magnitude_pkg;

  typedef logic [0:0] req_id_t;

  localparam int unsigned MAG_REQ_COUNT = 2;
  localparam int unsigned MAG_CNT_W     = 16;

endpackage

// File: rtl/magnitude_tag_fifo.sv
// In-order FIFO of requester IDs for transactions in flight through the magnitude pipeline.
module magnitude_tag_fifo
  import magnitude_pkg::*;
#(
  parameter int unsigned DEPTH_P = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  req_id_t                  push_id_i,
  input  logic                     pop_i,
  output req_id_t                  head_o,
  output logic [$clog2(DEPTH_P):0] count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH_P);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  req_id_t     r_mem [DEPTH_P];
  logic        w_push;
  logic        w_pop;

  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign empty_o = (r_wptr == r_rptr);
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count_o = r_wptr - r_rptr;
  assign head_o  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= push_id_i;
  end

endmodule

// File: rtl/magnitude_arbiter.sv
// Round-robin share of one magnitude pipeline between two requesters, with in-order return
// steering. Optional grant counters are built when MAGNITUDE_ARB_STATS_EN is defined.
module magnitude_arbiter
  import magnitude_pkg::*;
#(
  parameter int unsigned WIDTH_P     = 8,
  parameter int unsigned TAG_DEPTH_P = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         req0_valid_i,
  output logic                         req0_ready_o,
  input  logic [WIDTH_P-1:0]           req0_gx_i,
  input  logic [WIDTH_P-1:0]           req0_gy_i,
  input  logic                         req1_valid_i,
  output logic                         req1_ready_o,
  input  logic [WIDTH_P-1:0]           req1_gx_i,
  input  logic [WIDTH_P-1:0]           req1_gy_i,
  output logic                         mag_valid_o,
  input  logic                         mag_ready_i,
  output logic [WIDTH_P-1:0]           mag_gx_o,
  output logic [WIDTH_P-1:0]           mag_gy_o,
  input  logic                         mag_valid_i,
  output logic                         mag_ready_o,
  input  logic [2*WIDTH_P-1:0]         mag_i,
  output logic                         rsp0_valid_o,
  input  logic                         rsp0_ready_i,
  output logic                         rsp1_valid_o,
  input  logic                         rsp1_ready_i,
  output logic [2*WIDTH_P-1:0]         rsp_mag_o,
  output logic [$clog2(TAG_DEPTH_P):0] inflight_o,
  output logic [MAG_CNT_W-1:0]         grant0_cnt_o,
  output logic [MAG_CNT_W-1:0]         grant1_cnt_o
);

  req_id_t                  r_prio;
  req_id_t                  w_winner;
  req_id_t                  w_head;
  logic                     w_tag_full;
  logic                     w_tag_empty;
  logic                     w_issue;
  logic                     w_pop;
  logic [MAG_REQ_COUNT-1:0] w_grant;

  always_comb begin
    if (req0_valid_i && req1_valid_i) w_winner = r_prio;
    else                              w_winner = req1_valid_i;
  end

  assign mag_valid_o = (req0_valid_i | req1_valid_i) & ~w_tag_full;
  assign w_issue     = mag_valid_o & mag_ready_i;
  assign mag_gx_o    = w_winner[0] ? req1_gx_i : req0_gx_i;
  assign mag_gy_o    = w_winner[0] ? req1_gy_i : req0_gy_i;

  always_comb begin
    w_grant = '0;
    if (w_issue) w_grant[w_winner] = 1'b1;
  end

  assign req0_ready_o = w_grant[0];
  assign req1_ready_o = w_grant[1];

  // Results return strictly in issue order, so the FIFO head names the owner.
  assign rsp0_valid_o = mag_valid_i & ~w_tag_empty & ~w_head[0];
  assign rsp1_valid_o = mag_valid_i & ~w_tag_empty & w_head[0];
  assign mag_ready_o  = ~w_tag_empty & (w_head[0] ? rsp1_ready_i : rsp0_ready_i);
  assign rsp_mag_o    = mag_i;
  assign w_pop        = mag_valid_i & mag_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rstn_i)      r_prio <= '0;
    else if (w_issue) r_prio <= ~w_winner;
  end

  magnitude_tag_fifo #(
    .DEPTH_P (TAG_DEPTH_P)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .push_i    (w_issue),
    .push_id_i (w_winner),
    .pop_i     (w_pop),
    .head_o    (w_head),
    .count_o   (inflight_o),
    .full_o    (w_tag_full),
    .empty_o   (w_tag_empty)
  );

`ifdef MAGNITUDE_ARB_STATS_EN
  localparam logic [MAG_CNT_W-1:0] CntOne = {{(MAG_CNT_W-1){1'b0}}, 1'b1};

  logic [MAG_CNT_W-1:0] r_grant0_cnt;
  logic [MAG_CNT_W-1:0] r_grant1_cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
    end else begin
      if (w_grant[0] && (r_grant0_cnt != '1)) r_grant0_cnt <= r_grant0_cnt + CntOne;
      if (w_grant[1] && (r_grant1_cnt != '1)) r_grant1_cnt <= r_grant1_cnt + CntOne;
    end
  end

  assign grant0_cnt_o = r_grant0_cnt;
  assign grant1_cnt_o = r_grant1_cnt;
`else
  assign grant0_cnt_o = '0;
  assign grant1_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rstn_i && mag_valid_i && w_tag_empty) $error("magnitude result with no tag in flight");
  end
`endif

endmodule

// File: tb/tb_magnitude_arbiter.sv
// Randomized and directed bench for magnitude_arbiter; the bench itself plays the magnitude
// pipeline and checks against a queue-based model every cycle.
module tb_magnitude_arbiter;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic           clk_i = 1'b0;
  logic           rstn_i;
  logic           req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
  logic [W-1:0]   req0_gx_i, req0_gy_i, req1_gx_i, req1_gy_i;
  logic           mag_valid_o, mag_ready_i, mag_valid_i, mag_ready_o;
  logic [W-1:0]   mag_gx_o, mag_gy_o;
  logic [2*W-1:0] mag_i, rsp_mag_o;
  logic           rsp0_valid_o, rsp0_ready_i, rsp1_valid_o, rsp1_ready_i;
  logic [$clog2(DEPTH):0] inflight_o;
  logic [15:0]    grant0_cnt_o, grant1_cnt_o;

  magnitude_arbiter #(
    .WIDTH_P     (W),
    .TAG_DEPTH_P (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_gx_i    (req0_gx_i),
    .req0_gy_i    (req0_gy_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_gx_i    (req1_gx_i),
    .req1_gy_i    (req1_gy_i),
    .mag_valid_o  (mag_valid_o),
    .mag_ready_i  (mag_ready_i),
    .mag_gx_o     (mag_gx_o),
    .mag_gy_o     (mag_gy_o),
    .mag_valid_i  (mag_valid_i),
    .mag_ready_o  (mag_ready_o),
    .mag_i        (mag_i),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_ready_i (rsp0_ready_i),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_ready_i (rsp1_ready_i),
    .rsp_mag_o    (rsp_mag_o),
    .inflight_o   (inflight_o),
    .grant0_cnt_o (grant0_cnt_o),
    .grant1_cnt_o (grant1_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: tags in issue order, pending pipeline results, preferred requester, counts.
  int          q_tag[$];
  logic [15:0] mq[$];
  int          m_prio = 0;
  int          m_cnt0 = 0;
  int          m_cnt1 = 0;
  int          win_log[$];
  int          del_id[$];
  int          del_mag[$];
  int          ret_pct = 100;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle reference check, then advance the model to the state after the next edge.
  always @(negedge clk_i) begin
    int any, full, empty, exp_mv, win, iss, head, exp_rdy, gx, gy, exp_c0, exp_c1;
    any    = int'(req0_valid_i | req1_valid_i);
    full   = int'(q_tag.size() == DEPTH);
    empty  = int'(q_tag.size() == 0);
    exp_mv = int'(any == 1 && full == 0);
    if (req0_valid_i && req1_valid_i) win = m_prio;
    else                              win = int'(req1_valid_i);
    iss = int'(exp_mv == 1 && mag_ready_i);
    gx  = win == 1 ? int'(req1_gx_i) : int'(req0_gx_i);
    gy  = win == 1 ? int'(req1_gy_i) : int'(req0_gy_i);
    chk("mag_valid_o", int'(mag_valid_o), exp_mv);
    chk("req0_ready_o", int'(req0_ready_o), int'(iss == 1 && win == 0));
    chk("req1_ready_o", int'(req1_ready_o), int'(iss == 1 && win == 1));
    if (exp_mv == 1) begin
      chk("mag_gx_o", int'(mag_gx_o), gx);
      chk("mag_gy_o", int'(mag_gy_o), gy);
    end
    head    = empty == 1 ? 0 : q_tag[0];
    exp_rdy = empty == 1 ? 0 : (head == 1 ? int'(rsp1_ready_i) : int'(rsp0_ready_i));
    chk("mag_ready_o", int'(mag_ready_o), exp_rdy);
    chk("rsp0_valid_o", int'(rsp0_valid_o), int'(mag_valid_i && empty == 0 && head == 0));
    chk("rsp1_valid_o", int'(rsp1_valid_o), int'(mag_valid_i && empty == 0 && head == 1));
    if (mag_valid_i) chk("rsp_mag_o", int'(rsp_mag_o), int'(mag_i));
    chk("inflight_o", int'(inflight_o), q_tag.size());
`ifdef MAGNITUDE_ARB_STATS_EN
    exp_c0 = m_cnt0;
    exp_c1 = m_cnt1;
`else
    exp_c0 = 0;
    exp_c1 = 0;
`endif
    chk("grant0_cnt_o", int'(grant0_cnt_o), exp_c0);
    chk("grant1_cnt_o", int'(grant1_cnt_o), exp_c1);

    if (!rstn_i) begin
      q_tag.delete();
      mq.delete();
      m_prio = 0;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (mag_valid_i && exp_rdy == 1) begin
        del_id.push_back(head);
        del_mag.push_back(int'(mag_i));
        void'(q_tag.pop_front());
        void'(mq.pop_front());
      end
      if (iss == 1) begin
        q_tag.push_back(win);
        mq.push_back(16'(gx * gx + gy * gy));
        win_log.push_back(win);
        m_prio = 1 - win;
        if (win == 0 && m_cnt0 < 65535) m_cnt0++;
        if (win == 1 && m_cnt1 < 65535) m_cnt1++;
      end
    end
  end

  // Stand-in for the magnitude pipeline: one-cycle minimum latency, random return stalls.
  initial begin
    mag_valid_i = 1'b0;
    mag_i       = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mq.size() > 0 && $urandom_range(99) < ret_pct) begin
        mag_valid_i = 1'b1;
        mag_i       = mq[0];
      end else begin
        mag_valid_i = 1'b0;
        mag_i       = 16'($urandom);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input logic v0, input logic v1);
    req0_valid_i = v0;
    req1_valid_i = v1;
    req0_gx_i    = 8'($urandom);
    req0_gy_i    = 8'($urandom);
    req1_gx_i    = 8'($urandom);
    req1_gy_i    = 8'($urandom);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    step();
    rstn_i = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((inflight_o != 0 || mq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk(name, int'(inflight_o), 0);
  endtask

  initial begin
    int exp_pat[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int base;
    rstn_i       = 1'b0;
    mag_ready_i  = 1'b1;
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    set_req(1'b0, 1'b0);
    repeat (3) step();
    rstn_i = 1'b1;
    settle();
    chk("reset_inflight", int'(inflight_o), 0);
    chk("reset_mag_valid", int'(mag_valid_o), 0);

    // Single requester: 3*3 + 4*4 returns to requester 0.
    step();
    req0_valid_i = 1'b1;
    req0_gx_i    = 8'd3;
    req0_gy_i    = 8'd4;
    step();
    req0_valid_i = 1'b0;
    wait_idle("single_drain");
    chk("single_count", del_id.size(), 1);
    if (del_id.size() >= 1) begin
      chk("single_id", del_id[0], 0);
      chk("single_mag", del_mag[0], 25);
    end

    // Contention right after reset alternates starting with requester 0.
    do_reset();
    win_log.delete();
    repeat (8) begin
      set_req(1'b1, 1'b1);
      step();
    end
    set_req(1'b0, 1'b0);
    wait_idle("contention_drain");
    chk("contention_count", win_log.size(), 8);
    for (int i = 0; i < 8 && i < win_log.size(); i++) chk("contention_grant", win_log[i], exp_pat[i]);

    // Full: sinks stalled, exactly DEPTH issues.
    win_log.delete();
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    repeat (6) begin
      set_req(1'b1, 1'b1);
      step();
    end
    settle();
    chk("full_inflight", int'(inflight_o), 4);
    chk("full_mag_valid", int'(mag_valid_o), 0);
    chk("full_req0_ready", int'(req0_ready_o), 0);
    chk("full_req1_ready", int'(req1_ready_o), 0);
    chk("full_issues", win_log.size(), 4);
    set_req(1'b0, 1'b0);
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    wait_idle("full_drain");

    // Head-of-line: order 0 then 1, requester 0 sink stalled.
    base         = del_id.size();
    rsp0_ready_i = 1'b0;
    set_req(1'b1, 1'b0);
    step();
    set_req(1'b0, 1'b1);
    step();
    set_req(1'b0, 1'b0);
    repeat (5) begin
      step();
      settle();
      chk("hol_mag_ready", int'(mag_ready_o), 0);
      chk("hol_rsp1_valid", int'(rsp1_valid_o), 0);
      chk("hol_no_delivery", del_id.size(), base);
    end
    rsp0_ready_i = 1'b1;
    wait_idle("hol_drain");
    chk("hol_count", del_id.size(), base + 2);
    if (del_id.size() == base + 2) begin
      chk("hol_first", del_id[base], 0);
      chk("hol_second", del_id[base+1], 1);
    end

    // Random traffic with random stalls on every interface.
    ret_pct = 70;
    repeat (400) begin
      set_req(1'($urandom_range(9) < 7), 1'($urandom_range(9) < 7));
      mag_ready_i  = 1'($urandom_range(9) < 8);
      rsp0_ready_i = 1'($urandom_range(9) < 7);
      rsp1_ready_i = 1'($urandom_range(9) < 7);
      step();
    end
    set_req(1'b0, 1'b0);
    mag_ready_i  = 1'b1;
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    ret_pct      = 100;
    wait_idle("random_drain");

    // Reset with three tags in flight.
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    repeat (3) begin
      set_req(1'b1, 1'b0);
      step();
    end
    set_req(1'b0, 1'b0);
    settle();
    chk("midreset_pre", int'(inflight_o), 3);
    do_reset();
    settle();
    chk("midreset_inflight", int'(inflight_o), 0);
    win_log.delete();
    set_req(1'b1, 1'b1);
    step();
    set_req(1'b0, 1'b0);
    settle();
    chk("midreset_grants", win_log.size(), 1);
    if (win_log.size() == 1) chk("midreset_first", win_log[0], 0);
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    wait_idle("midreset_drain");

`ifdef MAGNITUDE_ARB_STATS_EN
    do_reset();
    repeat (70000) begin
      set_req(1'b1, 1'b0);
      step();
    end
    set_req(1'b0, 1'b0);
    wait_idle("stats_drain");
    settle();
    chk("stats_sat0", int'(grant0_cnt_o), 65535);
    chk("stats_cnt1", int'(grant1_cnt_o), 0);
`else
    settle();
    chk("stats_off0", int'(grant0_cnt_o), 0);
    chk("stats_off1", int'(grant1_cnt_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/magnitude_arbiter.md
# magnitude_arbiter

Round-robin arbiter sharing one `magnitude` pipeline between two independent gradient streams, so that a single pair of SB_MAC16 multipliers serves both the luma and the secondary Sobel channel. It grants one (gx, gy) pair per cycle into `magnitude` and records the requester ID of every in-flight transaction in a tag FIFO. It steers each returning magnitude back to the requester that issued it, in issue order, with full valid/ready backpressure on all five interfaces.

## Interface
- `WIDTH_P`, 8, gradient component width; magnitude width is 2*WIDTH_P
- `TAG_DEPTH_P`, 4, max in-flight transactions; power of two, at least 2
- `clk_i`  in  1  clock, all logic rising-edge
- `rstn_i`  in  1  reset, synchronous, active-low
- `req0_valid_i` / `req1_valid_i`  in  1  requester n has a gradient pair
- `req0_ready_o` / `req1_ready_o`  out  1  requester n pair accepted this cycle
- `req0_gx_i`, `req0_gy_i`, `req1_gx_i`, `req1_gy_i`  in  WIDTH_P  unsigned gradient components
- `mag_valid_o`  out  1  pair presented to `magnitude` `valid_i`
- `mag_ready_i`  in  1  from `magnitude` `ready_o`
- `mag_gx_o`, `mag_gy_o`  out  WIDTH_P  muxed gradient pair
- `mag_valid_i`  in  1  from `magnitude` `valid_o`
- `mag_ready_o`  out  1  to `magnitude` `ready_i`
- `mag_i`  in  2*WIDTH_P  magnitude result
- `rsp0_valid_o` / `rsp1_valid_o`  out  1  result for requester n
- `rsp0_ready_i` / `rsp1_ready_i`  in  1  requester n sink ready
- `rsp_mag_o`  out  2*WIDTH_P  result data, shared by both response ports
- `inflight_o`  out  $clog2(TAG_DEPTH_P)+1  tag FIFO occupancy
- `grant0_cnt_o` / `grant1_cnt_o`  out  16  grant counters (see Configuration)

## Operation
- Issue condition: `mag_valid_o` = (req0_valid_i | req1_valid_i) & !tag_full.
- Grant rule: if exactly one requester is valid, that requester wins. If both are valid, the one selected by `prio` wins. `prio` is a 1-bit register holding the preferred requester.
- Issue event: `issue` = mag_valid_o & mag_ready_i. On issue:
  - `reqN_ready_o` is high for the winner only.
  - The winner ID is pushed to the tag FIFO.
  - `prio` is set to the loser ID.
- `prio` holds when there is no issue.
- `mag_gx_o`/`mag_gy_o` carry the winner's data whenever `mag_valid_o` is high. They are don't-care otherwise.
- Response steering: `head` is the tag FIFO head.
  - `rsp<head>_valid_o` = mag_valid_i & !tag_empty. The other response valid is 0.
  - `mag_ready_o` = !tag_empty & rsp<head>_ready_i.
  - `rsp_mag_o` = `mag_i`.
- Pop event: `pop` = mag_valid_i & mag_ready_o. On pop, the tag FIFO pops.
- Push and pop in the same cycle are legal whenever not full. `inflight_o` is then unchanged.
- Full: no issue, both `reqN_ready_o` are 0, and pop proceeds normally. Full plus push cannot occur.
- Empty: `mag_ready_o` = 0. A `mag_valid_i` arriving while empty is a protocol error: `$error` in simulation, ignored in synthesis.
- Head-of-line blocking is intentional. A stalled sink for requester 0 blocks results for requester 1 behind it.

## Timing
- Issue path is combinational; the arbiter adds 0 cycles of latency.
- End-to-end latency equals `magnitude` latency (register plus elastic stage) only.
- State updates (`prio`, tag FIFO, counters) take effect on the clock edge after the qualifying event.
- Reset (`rstn_i` low at a clock edge):
  - tag FIFO empties and `inflight_o` = 0
  - `prio` = 0
  - counters = 0
- Combinational outputs during reset follow the rules above with the FIFO empty.
- Mid-operation reset discards all in-flight tags. `magnitude` must be reset by the same `rstn_i`, so no orphan results return.

## Configuration
- `MAGNITUDE_ARB_STATS_EN` defined:
  - `grantN_cnt_o` increments by 1 on each issue won by requester N.
  - Counters saturate at 16'hFFFF.
- `MAGNITUDE_ARB_STATS_EN` undefined: counters are not built and `grantN_cnt_o` are tied to 0. The ports are always present.

## Structure
- `magnitude_pkg` holds:
  - `typedef logic [0:0] req_id_t`
  - localparam `MAG_REQ_COUNT = 2`
  - the 16-bit counter width constant
- Sub-module `magnitude_tag_fifo`:
  - parameterized depth, stores `req_id_t`
  - read and write pointers are $clog2(depth)+1 bits, with full/empty derived from the MSB compare
  - combinational head read
  - outputs `count`, `full`, `empty`
- The arbiter top instantiates one `magnitude_tag_fifo`. It does not instantiate `magnitude`; the sobel top connects the two.

## Test plan
- Single requester: req0 issues gx=3, gy=4 with the `magnitude` model. Expect `rsp0_valid_o` with the LUT value for (9,16); `rsp1_valid_o` never asserts; `inflight_o` returns to 0.
- Contention: both requesters valid continuously for 8 cycles with all sinks ready. Expect grants alternating 0,1,0,1…, starting with 0 after reset, and each response routed to its issuer.
- Full: hold all sinks not ready with TAG_DEPTH_P=4. Expect exactly 4 issues, then `mag_valid_o`=0, both `reqN_ready_o`=0, and `inflight_o`=4.
- Head-of-line blocking: in-flight order 0,1 with `rsp0_ready_i`=0 for 5 cycles. Expect `mag_ready_o`=0 and no rsp1 delivery until rsp0 is accepted; then the in-order drain completes.
- Reset mid-stream: assert `rstn_i`=0 with 3 tags in flight. Next cycle expect `inflight_o`=0, `prio`=0, and the first post-reset contention granting 0.
- Stats: with `MAGNITUDE_ARB_STATS_EN` defined, 70000 req0-only issues give `grant0_cnt_o`=16'hFFFF. With it undefined, both counters stay 0.
